root_result_buffer: RTL

ROOT_RESULT_BUFFER -- requirements
Module: root_result_buffer

---
 rtl/root_result_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/root_result_buffer.sv
// root_result_buffer
//   Captures square-root stage results on the rising edge of ready_i,
//   checks each result against its operand (remainder within 0..2*root)
//   and queues root/remainder/error entries in a small FIFO.
//
// Ports
//   clk        : single clock, rising-edge state updates
//   rst        : synchronous, active-high reset
//   valor_i    : 16-bit operand presented to the square-root stage
//   root_i     : 8-bit root produced by the square-root stage
//   ready_i    : completion level; only its 0->1 transition captures
//   accept_i   : downstream ready; pops the head when valid_o is high
//   valid_o    : head entry available
//   root_o     : head root (0 when empty)
//   rem_o      : head remainder, 9'h1FF on error (0 when empty)
//   err_o      : head failed the consistency check (0 when empty)
//   count_o    : occupied entries, 0..DEPTH
//   overflow_o : sticky, set when a capture was dropped on a full FIFO
module root_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              valor_i,
  input  logic [7:0]               root_i,
  input  logic                     ready_i,
  input  logic                     accept_i,
  output logic                     valid_o,
  output logic [7:0]               root_o,
  output logic [8:0]               rem_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          ready_prev;
  logic          cap;
  logic          s1_valid;
  logic [15:0]   s1_valor;
  logic [7:0]    s1_root;

  logic [15:0]        sq;
  logic signed [16:0] rem;
  logic               err;
  logic [8:0]         rem_st;
  logic [17:0]        entry;

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr;
  logic [17:0]   head;

  assign cap = ready_i & ~ready_prev;

  // Remainder is signed so an undersized operand (sq > valor) shows up as
  // negative; both error conditions then reduce to range checks.
  always_comb begin
    sq     = 16'(s1_root) * 16'(s1_root);
    rem    = $signed({1'b0, s1_valor}) - $signed({1'b0, sq});
    err    = (sq > s1_valor) || (rem > $signed({8'b0, s1_root, 1'b0}));
    rem_st = err ? 9'h1FF : rem[8:0];
    entry  = {err, rem_st, s1_root};
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & accept_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr    = s1_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_prev <= 1'b1;
      s1_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      ready_prev <= ready_i;
      s1_valid   <= cap;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s1_valid && !wr) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      s1_valor <= valor_i;
      s1_root  <= root_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    valid_o    = ~empty;
    root_o     = '0;
    rem_o      = '0;
    err_o      = 1'b0;
    if (!empty) begin
      root_o = head[7:0];
      rem_o  = head[16:8];
      err_o  = head[17];
    end
    count_o    = count;
    overflow_o = overflow;
  end

endmodule
